// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, vector defaults and PC helper for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;
    localparam int          KERNEL_BIT   = 31;

    // Sequential increment wraps inside the current privilege half of the address space.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        pc_inc = {pc[KERNEL_BIT], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC priority mux for the fetch sequencer
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  fetch_state_e i_state,
    input  logic [31:0]  i_pc,
    input  logic         i_stall,
    input  logic         i_redirect_en,
    input  logic [31:0]  i_redirect_pc,
    input  logic         i_exc,
    input  logic         i_irq_pend,
    output logic [31:0]  o_next_pc,
    output fetch_state_e o_next_state,
    output logic         o_next_valid,
    output logic         o_take_exc,
    output logic         o_take_irq,
    output logic         o_take_redirect
);

    logic w_run;
    logic w_user;

    assign w_run  = (i_state == RUN);
    assign w_user = ~i_pc[KERNEL_BIT];

    always_comb begin
        o_next_pc       = pc_inc(i_pc);
        o_next_state    = RUN;
        o_next_valid    = 1'b1;
        o_take_exc      = 1'b0;
        o_take_irq      = 1'b0;
        o_take_redirect = 1'b0;
        // BOOT always fetches sequentially; TRAP fetches with exc/irq masked.
        if (i_state != BOOT) begin
            if (w_run && i_exc) begin
                o_take_exc   = 1'b1;
                o_next_pc    = EXC_VEC;
                o_next_valid = 1'b0;
                o_next_state = TRAP;
            end else if (w_run && i_irq_pend && w_user && !i_stall) begin
                o_take_irq   = 1'b1;
                o_next_pc    = IRQ_VEC;
                o_next_valid = 1'b0;
                o_next_state = TRAP;
            end else if (i_redirect_en) begin
                o_take_redirect = 1'b1;
                o_next_pc       = {i_redirect_pc[KERNEL_BIT] & ~w_user, i_redirect_pc[30:0]};
                o_next_valid    = 1'b0;
            end else if (i_stall) begin
                o_next_pc = i_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC owner, IF/ID latch and trap vectoring; FETCH_PERF_CNT_EN adds perf counters
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_ins,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    input  logic [31:0] exc_pc,
    input  logic        irq,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        flush_id,
    output logic        epc_we,
    output logic [31:0] epc,
    output logic        kernel,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_if_id_ins;
    logic [31:0]  r_if_id_pc;
    logic         r_if_id_valid;
    logic         r_epc_we;
    logic [31:0]  r_epc;
    logic         r_irq_pend;

    fetch_state_e w_next_state;
    logic [31:0]  w_next_pc;
    logic         w_next_valid;
    logic         w_take_exc;
    logic         w_take_irq;
    logic         w_take_redirect;
    logic         w_irq_pend;
    logic         w_hold;

    // A request arriving this cycle is eligible immediately, not only once latched.
    assign w_irq_pend = r_irq_pend | irq;
    assign w_hold     = stall & (r_state != BOOT) & ~(w_take_exc | w_take_irq | w_take_redirect);

    fetch_next_pc #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_next_pc (
        .i_state         (r_state),
        .i_pc            (r_pc),
        .i_stall         (stall),
        .i_redirect_en   (redirect_en),
        .i_redirect_pc   (redirect_pc),
        .i_exc           (exc),
        .i_irq_pend      (w_irq_pend),
        .o_next_pc       (w_next_pc),
        .o_next_state    (w_next_state),
        .o_next_valid    (w_next_valid),
        .o_take_exc      (w_take_exc),
        .o_take_irq      (w_take_irq),
        .o_take_redirect (w_take_redirect)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_if_id_ins   <= '0;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
            r_epc_we      <= 1'b0;
            r_epc         <= '0;
            r_irq_pend    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_epc_we   <= w_take_exc | w_take_irq;
            r_irq_pend <= w_take_irq ? 1'b0 : w_irq_pend;
            if (!w_hold) begin
                r_if_id_ins   <= imem_ins;
                r_if_id_pc    <= r_pc;
                r_if_id_valid <= w_next_valid;
            end
            if (w_take_exc) begin
                r_epc <= pc_inc(exc_pc);
            end else if (w_take_irq) begin
                r_epc <= redirect_en ? redirect_pc : r_pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else if (!w_hold && w_next_valid) begin
            r_perf_fetch  <= r_perf_fetch + 32'd1;
        end else begin
            r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_fetch  = r_perf_fetch;
    assign perf_bubble = r_perf_bubble;
`else
    assign perf_fetch  = '0;
    assign perf_bubble = '0;
`endif

    assign imem_addr   = r_pc;
    assign kernel      = r_pc[KERNEL_BIT];
    assign if_id_ins   = r_if_id_ins;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign flush_id    = w_take_exc;
    assign epc_we      = r_epc_we;
    assign epc         = r_epc;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - self-checking bench for fetch_pc_ctrl with a behavioural reference model
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr, imem_ins, if_id_ins, if_id_pc, epc, perf_fetch, perf_bubble;
    logic        stall = 1'b0, redirect_en = 1'b0, exc = 1'b0, irq = 1'b0;
    logic [31:0] redirect_pc = '0, exc_pc = '0;
    logic        if_id_valid, flush_id, epc_we, kernel;
    int          errors = 0, checks = 0;

    logic [31:0] m_pc, m_ins, m_ipc, m_epc, m_fetch, m_bubble;
    bit          m_valid, m_epc_we, m_pend;
    int          m_st;

    fetch_pc_ctrl dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_ins(imem_ins),
        .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .exc(exc), .exc_pc(exc_pc), .irq(irq),
        .if_id_ins(if_id_ins), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .flush_id(flush_id), .epc_we(epc_we), .epc(epc), .kernel(kernel),
        .perf_fetch(perf_fetch), .perf_bubble(perf_bubble)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_ins = rom(imem_addr);

    function automatic logic [31:0] kinc(input logic [31:0] a);
        return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    // Model state: m_st 0 = first cycle after reset, 1 = normal, 2 = cycle after a trap.
    task automatic model_update();
        logic [31:0] n_pc;
        bit n_valid, hold, trap, pe;
        int n_st;
        if (!reset) begin
            m_pc = 32'h0040_0000; m_ins = 0; m_ipc = 0; m_valid = 0; m_epc_we = 0; m_epc = 0;
            m_pend = 0; m_st = 0; m_fetch = 0; m_bubble = 0;
            return;
        end
        pe = m_pend | irq;
        n_pc = kinc(m_pc); n_valid = 1; n_st = 1; hold = 0; trap = 0;
        if (m_st == 1 && exc) begin
            n_pc = 32'h8000_0008; n_valid = 0; n_st = 2; trap = 1; m_epc = kinc(exc_pc);
        end else if (m_st == 1 && pe && m_pc < 32'h8000_0000 && !stall) begin
            n_pc = 32'h8000_0004; n_valid = 0; n_st = 2; trap = 1; pe = 0;
            m_epc = redirect_en ? redirect_pc : m_pc;
        end else if (m_st != 0 && redirect_en) begin
            n_pc = (m_pc >= 32'h8000_0000) ? redirect_pc : (redirect_pc & 32'h7FFF_FFFF);
            n_valid = 0;
        end else if (m_st != 0 && stall) begin
            hold = 1; n_pc = m_pc;
        end
        m_pend = pe;
        m_epc_we = trap;
        if (!hold) begin m_ins = rom(m_pc); m_ipc = m_pc; m_valid = n_valid; end
        if (!hold && n_valid) m_fetch = m_fetch + 1; else m_bubble = m_bubble + 1;
        m_pc = n_pc; m_st = n_st;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect_en = 0; exc = 0; irq = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h0040_0000; exp_addr[1] = 32'h0040_0004; exp_addr[2] = 32'h0040_0008;
        idle(); reset = 0;
        repeat (3) step();
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rst_pc got=%h exp=%h", imem_addr, 32'h0040_0000); end
        checks++; if (if_id_valid !== 1'b0 || epc_we !== 1'b0 || epc !== 32'h0 || kernel !== 1'b0)
            begin errors++; $display("FAIL rst_outs got valid=%b epc_we=%b epc=%h kernel=%b exp 0", if_id_valid, epc_we, epc, kernel); end
        checks++; if (if_id_pc !== 32'h0 || if_id_ins !== 32'h0) begin errors++; $display("FAIL rst_if_id got pc=%h ins=%h exp 0", if_id_pc, if_id_ins); end
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_addr !== exp_addr[i]) begin errors++; $display("FAIL boot_seq%0d got=%h exp=%h", i, imem_addr, exp_addr[i]); end
            checks++; if (if_id_valid !== (i != 0)) begin errors++; $display("FAIL boot_valid%0d got=%b exp=%b", i, if_id_valid, i != 0); end
            if (i < 2) step();
        end
        checks++; if (if_id_pc !== 32'h0040_0004 || if_id_ins !== rom(32'h0040_0004))
            begin errors++; $display("FAIL boot_if_id got pc=%h ins=%h exp pc=%h ins=%h", if_id_pc, if_id_ins, 32'h0040_0004, rom(32'h0040_0004)); end
    endtask

    task automatic test_redirect();
        int n = 0;
        while (imem_addr !== 32'h0040_0048 && n < 64) begin step(); n++; end
        checks++; if (imem_addr !== 32'h0040_0048) begin errors++; $display("FAIL reach_48 got=%h exp=%h", imem_addr, 32'h0040_0048); end
        redirect_en = 1; redirect_pc = 32'h0040_0054; step(); idle();
        checks++; if (imem_addr !== 32'h0040_0054) begin errors++; $display("FAIL redir_pc got=%h exp=%h", imem_addr, 32'h0040_0054); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got=%b exp=0", if_id_valid); end
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0054 || if_id_ins !== rom(32'h0040_0054))
            begin errors++; $display("FAIL redir_first got valid=%b pc=%h exp valid=1 pc=%h", if_id_valid, if_id_pc, 32'h0040_0054); end
        redirect_en = 1; redirect_pc = 32'h8000_0010; step(); idle();
        checks++; if (imem_addr !== 32'h0000_0010 || kernel !== 1'b0)
            begin errors++; $display("FAIL redir_user got=%h kernel=%b exp=%h kernel=0", imem_addr, kernel, 32'h0000_0010); end
    endtask

    task automatic test_irq();
        redirect_en = 1; redirect_pc = 32'h0040_0100; step(); idle();
        checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL irq_setup got=%h exp=%h", imem_addr, 32'h0040_0100); end
        irq = 1; step(); irq = 0;
        checks++; if (imem_addr !== 32'h8000_0004 || kernel !== 1'b1)
            begin errors++; $display("FAIL irq_vec got=%h kernel=%b exp=%h kernel=1", imem_addr, kernel, 32'h8000_0004); end
        checks++; if (epc_we !== 1'b1 || epc !== 32'h0040_0100) begin errors++; $display("FAIL irq_epc got we=%b epc=%h exp we=1 epc=%h", epc_we, epc, 32'h0040_0100); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL irq_bubble got=%b exp=0", if_id_valid); end
        step();
        checks++; if (epc_we !== 1'b0 || epc !== 32'h0040_0100) begin errors++; $display("FAIL irq_epc_hold got we=%b epc=%h exp we=0 epc=%h", epc_we, epc, 32'h0040_0100); end
        irq = 1; step(); irq = 0; step();
        checks++; if (imem_addr !== 32'h8000_0010 || epc_we !== 1'b0)
            begin errors++; $display("FAIL irq_kernel_masked got pc=%h we=%b exp pc=%h we=0", imem_addr, epc_we, 32'h8000_0010); end
        redirect_en = 1; redirect_pc = 32'h0040_0104; step(); idle();
        checks++; if (imem_addr !== 32'h0040_0104) begin errors++; $display("FAIL kexit got=%h exp=%h", imem_addr, 32'h0040_0104); end
        step();
        checks++; if (imem_addr !== 32'h8000_0004 || epc_we !== 1'b1 || epc !== 32'h0040_0104)
            begin errors++; $display("FAIL irq_pending got pc=%h we=%b epc=%h exp pc=%h we=1 epc=%h", imem_addr, epc_we, epc, 32'h8000_0004, 32'h0040_0104); end
        step();
        redirect_en = 1; redirect_pc = 32'h0040_0000; step(); idle();
        irq = 1; redirect_en = 1; redirect_pc = 32'h0040_0060; step(); idle();
        checks++; if (imem_addr !== 32'h8000_0004 || epc !== 32'h0040_0060 || epc_we !== 1'b1)
            begin errors++; $display("FAIL irq_redir got pc=%h epc=%h we=%b exp pc=%h epc=%h we=1", imem_addr, epc, epc_we, 32'h8000_0004, 32'h0040_0060); end
    endtask

    task automatic test_exc();
        step(); step();
        stall = 1; exc = 1; exc_pc = 32'h0040_0200; #1;
        checks++; if (flush_id !== 1'b1) begin errors++; $display("FAIL exc_flush got=%b exp=1", flush_id); end
        step(); idle();
        checks++; if (imem_addr !== 32'h8000_0008 || epc_we !== 1'b1 || epc !== 32'h0040_0204)
            begin errors++; $display("FAIL exc_vec got pc=%h we=%b epc=%h exp pc=%h we=1 epc=%h", imem_addr, epc_we, epc, 32'h8000_0008, 32'h0040_0204); end
        exc = 1; exc_pc = 32'h0040_0300; #1;
        checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL exc_trap_flush got=%b exp=0", flush_id); end
        step(); idle();
        checks++; if (imem_addr !== 32'h8000_000C || epc_we !== 1'b0 || epc !== 32'h0040_0204)
            begin errors++; $display("FAIL exc_trap_masked got pc=%h we=%b epc=%h exp pc=%h we=0 epc=%h", imem_addr, epc_we, epc, 32'h8000_000C, 32'h0040_0204); end
    endtask

    task automatic test_stall();
        logic [31:0] s_pc, s_ins, s_ipc, s_bub;
        redirect_en = 1; redirect_pc = 32'h0040_0400; step(); idle(); step();
        s_pc = imem_addr; s_ins = if_id_ins; s_ipc = if_id_pc; s_bub = perf_bubble;
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (imem_addr !== s_pc || if_id_ins !== s_ins || if_id_pc !== s_ipc || if_id_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold%0d got pc=%h ipc=%h valid=%b exp pc=%h ipc=%h valid=1", i, imem_addr, if_id_pc, if_id_valid, s_pc, s_ipc); end
        end
        idle();
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_bubble - s_bub !== 32'd4) begin errors++; $display("FAIL stall_perf got=%0d exp=4", perf_bubble - s_bub); end
`else
        checks++; if (perf_bubble !== 32'h0 || perf_fetch !== 32'h0 || s_bub !== 32'h0)
            begin errors++; $display("FAIL perf_tied got fetch=%h bubble=%h exp 0", perf_fetch, perf_bubble); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset       = ($urandom_range(0, 99) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect_en = ($urandom_range(0, 6) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            exc         = ($urandom_range(0, 19) == 0);
            exc_pc      = $urandom & 32'hFFFF_FFFC;
            irq         = ($urandom_range(0, 14) == 0);
            #1;
            checks++; if (flush_id !== (m_st == 1 && exc)) begin errors++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush_id, m_st == 1 && exc); end
            step();
            checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, imem_addr, m_pc); end
            checks++; if (kernel !== m_pc[31]) begin errors++; $display("FAIL rnd_kernel c=%0d got=%b exp=%b", c, kernel, m_pc[31]); end
            checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, if_id_valid, m_valid); end
            if (m_valid) begin
                checks++; if (if_id_pc !== m_ipc || if_id_ins !== m_ins)
                    begin errors++; $display("FAIL rnd_if_id c=%0d got pc=%h ins=%h exp pc=%h ins=%h", c, if_id_pc, if_id_ins, m_ipc, m_ins); end
            end
            checks++; if (epc_we !== m_epc_we) begin errors++; $display("FAIL rnd_epc_we c=%0d got=%b exp=%b", c, epc_we, m_epc_we); end
            checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd_epc c=%0d got=%h exp=%h", c, epc, m_epc); end
`ifdef FETCH_PERF_CNT_EN
            checks++; if (perf_fetch !== m_fetch || perf_bubble !== m_bubble)
                begin errors++; $display("FAIL rnd_perf c=%0d got f=%0d b=%0d exp f=%0d b=%0d", c, perf_fetch, perf_bubble, m_fetch, m_bubble); end
`endif
        end
        idle(); reset = 1;
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_irq();
        test_exc();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined MIPS core. It owns the PC and drives the combinational instruction ROM address.
- It registers the returned word into the IF/ID latch and arbitrates the next PC between sequential fetch, stall, branch/jump redirect, exception vector and interrupt vector.
- PC[31] is the kernel (supervisor) bit. Interrupts are taken only in user mode, and the controller supplies the EPC write to the register file ($k0).

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- IRQ_VEC, 32'h8000_0004, interrupt vector (kernel space).
- EXC_VEC, 32'h8000_0008, exception vector (kernel space).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  32  ROM read address, equal to pc.
- imem_ins  in  32  ROM read data, combinational from imem_addr.
- stall  in  1  load-use hazard; hold PC and IF/ID.
- redirect_en  in  1  taken branch/j/jal/jr resolved downstream.
- redirect_pc  in  32  target for redirect_en.
- exc  in  1  exception raised in ID (undefined opcode).
- exc_pc  in  32  PC of the faulting instruction.
- irq  in  1  timer interrupt request, level.
- if_id_ins  out  32  latched instruction.
- if_id_pc  out  32  PC of latched instruction.
- if_id_valid  out  1  latched instruction is live; 0 means bubble.
- flush_id  out  1  combinational; squash ID this cycle.
- epc_we  out  1  one-cycle write of EPC into $k0.
- epc  out  32  value for $k0.
- kernel  out  1  equals pc[31].
- perf_fetch  out  32  fetch count (optional feature).
- perf_bubble  out  32  bubble count (optional feature).

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_PC; if_id_ins=0, if_id_pc=0, if_id_valid=0.
  - epc_we=0, epc=0, irq_pend=0, state=BOOT.
  - Reset asserted mid-operation discards everything, including a pending IRQ.
- FSM has three states, BOOT, RUN and TRAP:
  - BOOT: the cycle after reset release.
    - pc<=pc+4; if_id <= {imem_ins, pc, valid=1}.
    - Goes to RUN.
    - exc, irq and redirect are ignored in BOOT.
  - RUN: normal operation, priority below.
  - TRAP: exactly one cycle after any vectoring.
    - Fetches normally.
    - exc and irq are masked.
    - Goes to RUN.
- irq_pend is set when irq==1 and cleared when the interrupt is accepted. exc is never latched.
- RUN priority, highest first:
  1. exc:
     - pc<=EXC_VEC; epc_we=1; epc=exc_pc+4; flush_id=1.
     - if_id_valid<=0; go to TRAP.
     - Taken even in kernel mode.
  2. irq_pend && !pc[31] && !stall:
     - pc<=IRQ_VEC; epc_we=1; if_id_valid<=0.
     - epc = redirect_en ? redirect_pc : pc, so a simultaneous redirect is folded into the EPC and not lost.
     - Clear irq_pend; go to TRAP.
  3. redirect_en:
     - pc<=redirect_pc, with bit 31 forced to 0 when pc[31]==0 (user code cannot enter kernel).
     - if_id_valid<=0 (wrong-path fetch squashed).
     - Redirect overrides stall.
  4. stall: pc, if_id_* and state hold.
  5. else: pc<=pc+4; if_id <= {imem_ins, pc, 1}.
- PC arithmetic:
  - pc+4 is computed on bits [30:0] with wrap; bit 31 is preserved.
  - Kernel exit happens only through a redirect to an address with bit 31 = 0 (jr $k0).
- epc_we is high for exactly one cycle per trap and is registered. epc holds its value afterwards.
- Interrupts are never accepted in kernel mode. irq_pend stays set and is accepted in the first eligible RUN cycle after returning to user mode.
- Latency: ROM word appears on if_id_ins 1 cycle after imem_addr; redirect-to-first-valid is 2 cycles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch increments on each cycle that loads if_id_valid=1.
  - perf_bubble increments on each cycle that loads if_id_valid=0 or holds for stall.
  - Both counters are 32-bit wrapping and reset to 0.
- Undefined: both outputs are tied to 0 and no counter registers are inferred.

Decomposition:
- Package fetch_pkg holds:
  - FSM state enum: BOOT, RUN, TRAP.
  - Defaults for RESET_PC, IRQ_VEC and EXC_VEC.
  - KERNEL_BIT=31.
- One natural sub-module, fetch_next_pc: a purely combinational priority mux producing next_pc, next_valid and the take_exc/take_irq/take_redirect strobes.

Test Plan:
- Reset low 3 cycles, then high:
  - imem_addr sequence is 0x00400000, 0x00400004, 0x00400008.
  - if_id_valid rises one cycle after release.
- At pc=0x00400048, redirect_en with redirect_pc=0x00400054:
  - next imem_addr=0x00400054; if_id_valid=0 for one cycle.
  - Repeat with redirect_pc=0x80000010 in user mode: pc=0x00000010.
- irq pulsed at pc=0x00400100:
  - next pc=0x80000004; epc_we=1 with epc=0x00400100; kernel=1.
  - Second irq pulse while in kernel is held; after redirect to 0x00400104 it vectors again.
- irq and redirect_en (0x00400060) in the same cycle:
  - pc=0x80000004 and epc=0x00400060.
- exc with exc_pc=0x00400200 during stall:
  - pc=0x80000008, epc=0x00400204, flush_id=1.
  - exc asserted again in the TRAP cycle is ignored.
- stall held 4 cycles: pc and if_id_* remain constant.
  - With FETCH_PERF_CNT_EN defined, perf_bubble increases by 4.
